// File: rtl/lcd_serial_tx_if.sv
// Avalon-MM slave bus bundle for lcd_serial_tx: register select, write strobe and read mux.
interface lcd_serial_tx_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lcd_serial_tx.sv
// Avalon-MM LCD serialiser: a small TX FIFO feeding an MSB-first SI/SCL shifter with A0 and CS_n.
// Bus handshake: a write is chipselect && !write_n on a rising clk, always accepted in that cycle (no wait states).
module lcd_serial_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  lcd_serial_tx_if.slave   bus,
  output logic             lcd_si,
  output logic             lcd_scl,
  output logic             lcd_a0,
  output logic             lcd_cs_n,
  output logic [2:0]       fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LO    = 3'd2,
    ST_HI    = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] div_reg;
  logic [15:0] div_lat;
  logic [15:0] cnt;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_cnt;
  logic        overflow;

  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] fifo_cnt;
  logic        fifo_full;
  logic        fifo_empty;
  logic [8:0]  fifo_head;

  logic        wr_en;
  logic        push_req;
  logic        pop;
  logic        push_ok;
  logic        busy;
  logic        unused_wdata;

  assign wr_en      = bus.chipselect && !bus.write_n;
  assign push_req   = wr_en && (bus.address == 2'd0);
  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_head  = mem[rd_ptr[AW-1:0]];
  assign pop        = (state == ST_IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still fits.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign busy       = (state != ST_IDLE) || !fifo_empty;
  assign fsm_state  = state;
  assign unused_wdata = ^bus.writedata[31:16];

  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      2'd1:    bus.readdata = {28'd0, overflow, fifo_empty, fifo_full, busy};
      2'd2:    bus.readdata = {16'd0, div_reg};
      default: bus.readdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= bus.writedata[8:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      div_reg  <= 16'(CLK_DIV);
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      // Set takes priority over a clear in the same cycle.
      if (push_req && !push_ok)
        overflow <= 1'b1;
      else if (wr_en && bus.address == 2'd1 && bus.writedata[3])
        overflow <= 1'b0;
      if (wr_en && bus.address == 2'd2) div_reg <= bus.writedata[15:0];
    end
  end

  // cnt counts down from the latched divider, so each timed state lasts DIV+1 cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      div_lat   <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      lcd_cs_n  <= 1'b1;
      lcd_scl   <= 1'b1;
      lcd_si    <= 1'b0;
      lcd_a0    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift_reg <= fifo_head[7:0];
            lcd_a0    <= fifo_head[8];
            lcd_si    <= fifo_head[7];
            lcd_cs_n  <= 1'b0;
            lcd_scl   <= 1'b1;
            div_lat   <= div_reg;
            cnt       <= div_reg;
            bit_cnt   <= '0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == 16'd0) begin
            cnt     <= div_lat;
            lcd_scl <= 1'b0;
            state   <= ST_LO;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_LO: begin
          if (cnt == 16'd0) begin
            cnt     <= div_lat;
            lcd_scl <= 1'b1;
            state   <= ST_HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HI: begin
          if (cnt == 16'd0) begin
            cnt <= div_lat;
            if (bit_cnt == 3'd7) begin
              state <= ST_HOLD;
            end else begin
              shift_reg <= {shift_reg[6:0], 1'b0};
              lcd_si    <= shift_reg[6];
              bit_cnt   <= bit_cnt + 1'b1;
              lcd_scl   <= 1'b0;
              state     <= ST_LO;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == 16'd0) begin
            lcd_cs_n <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          lcd_cs_n <= 1'b1;
          lcd_scl  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_serial_tx.sv
// Directed bench for lcd_serial_tx: register access, serial framing, FIFO overflow, DIV latching, reset abort.
module tb_lcd_serial_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       lcd_si, lcd_scl, lcd_a0, lcd_cs_n;
  logic [2:0] fsm_state;

  int checks = 0;
  int passed = 0;

  lcd_serial_tx_if bus ();

  lcd_serial_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .lcd_si    (lcd_si),
    .lcd_scl   (lcd_scl),
    .lcd_a0    (lcd_a0),
    .lcd_cs_n  (lcd_cs_n),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  // Pin monitor, sampled on the falling edge: received bytes, cs_n low/high run lengths, scl rises.
  logic [8:0] rx_q[$];
  int         len_q[$];
  int         gap_q[$];
  logic [7:0] mon_sh = '0;
  logic       prev_scl = 1'b1;
  logic       prev_cs = 1'b1;
  bit         seen_byte = 0;
  int         low_len = 0;
  int         high_len = 0;
  int         scl_lo_run = 0;
  int         last_scl_lo = 0;
  int         rise_cnt = 0;

  always @(negedge clk) begin
    if (!lcd_cs_n) begin
      if (prev_cs && seen_byte) gap_q.push_back(high_len);
      low_len++;
    end else begin
      if (!prev_cs) begin
        len_q.push_back(low_len);
        rx_q.push_back({lcd_a0, mon_sh});
        seen_byte = 1;
        low_len = 0;
        high_len = 0;
      end
      high_len++;
    end
    if (!lcd_scl && !lcd_cs_n) scl_lo_run++;
    if (lcd_scl && !prev_scl) begin
      rise_cnt++;
      if (!lcd_cs_n) begin
        mon_sh = {mon_sh[6:0], lcd_si};
        last_scl_lo = scl_lo_run;
      end
      scl_lo_run = 0;
    end
    prev_scl = lcd_scl;
    prev_cs  = lcd_cs_n;
  end

  task automatic clear_monitor();
    rx_q.delete();
    len_q.delete();
    gap_q.delete();
    seen_byte = 0;
    low_len = 0;
    high_len = 0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic wait_not_busy(input int budget, input string name);
    logic [31:0] st;
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      bus_read(2'd1, st);
      if (st[0] == 1'b0) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) $display("FAIL %s: busy still 1 after %0d reads, required 0", name, budget);
    else passed++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus_read(2'd1, d);
    checks++; if (d !== 32'h4) $display("FAIL reset_status: got %h want 4", d); else passed++;
    bus_read(2'd2, d);
    checks++; if (d !== 32'h4) $display("FAIL reset_div: got %h want 4", d); else passed++;
    checks++; if (lcd_cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", lcd_cs_n); else passed++;
    checks++; if (lcd_scl !== 1'b1) $display("FAIL reset_scl: got %b want 1", lcd_scl); else passed++;
    checks++; if (lcd_si !== 1'b0) $display("FAIL reset_si: got %b want 0", lcd_si); else passed++;
    checks++; if (lcd_a0 !== 1'b0) $display("FAIL reset_a0: got %b want 0", lcd_a0); else passed++;
  endtask

  task automatic test_byte_div0();
    logic [8:0]  got;
    int          len;
    logic [31:0] st;
    bus_write(2'd2, 32'd0);
    clear_monitor();
    bus_write(2'd0, 32'h1A5);
    @(negedge clk);
    checks++; if (lcd_cs_n !== 1'b1) $display("FAIL start_cs_edge0: got %b want 1", lcd_cs_n); else passed++;
    @(negedge clk);
    checks++; if (lcd_cs_n !== 1'b0) $display("FAIL start_cs_edge1: got %b want 0", lcd_cs_n); else passed++;
    checks++; if (lcd_a0 !== 1'b1) $display("FAIL start_a0: got %b want 1", lcd_a0); else passed++;
    checks++; if (lcd_si !== 1'b1) $display("FAIL start_si_bit7: got %b want 1", lcd_si); else passed++;
    wait_not_busy(60, "div0_done");
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
    checks++; if (got !== 9'h1A5) $display("FAIL div0_byte: got %h want 1a5", got); else passed++;
    len = (len_q.size() > 0) ? len_q.pop_front() : -1;
    checks++; if (len != 18) $display("FAIL div0_cs_low: got %0d want 18", len); else passed++;
    bus_read(2'd1, st);
    checks++; if (st !== 32'h4) $display("FAIL div0_status_idle: got %h want 4", st); else passed++;
  endtask

  task automatic test_byte_div2();
    logic [8:0] got;
    int         len;
    bus_write(2'd2, 32'd2);
    clear_monitor();
    bus_write(2'd0, 32'h03C);
    wait_not_busy(120, "div2_done");
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
    checks++; if (got !== 9'h03C) $display("FAIL div2_byte: got %h want 03c", got); else passed++;
    len = (len_q.size() > 0) ? len_q.pop_front() : -1;
    checks++; if (len != 54) $display("FAIL div2_cs_low: got %0d want 54", len); else passed++;
    checks++; if (last_scl_lo != 3) $display("FAIL div2_scl_half: got %0d want 3", last_scl_lo); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [8:0]  exp_q[$];
    logic [8:0]  got;
    logic [31:0] st;
    int          len;
    bus_write(2'd2, 32'd0);
    clear_monitor();
    exp_q = '{9'h111, 9'h022, 9'h133, 9'h044, 9'h155};
    bus_write(2'd0, 32'h111);
    bus_write(2'd0, 32'h022);
    bus_write(2'd0, 32'h133);
    bus_write(2'd0, 32'h044);
    bus_write(2'd0, 32'h155);
    bus_write(2'd0, 32'h066);
    bus_read(2'd1, st);
    checks++; if (st !== 32'hB) $display("FAIL b2b_status_full_ovf: got %h want b", st); else passed++;
    wait_not_busy(200, "b2b_done");
    for (int i = 0; i < 5; i++) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
      checks++; if (got !== exp_q[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp_q[i]); else passed++;
      len = (len_q.size() > 0) ? len_q.pop_front() : -1;
      checks++; if (len != 18) $display("FAIL b2b_len%0d: got %0d want 18", i, len); else passed++;
    end
    checks++; if (rx_q.size() != 0) $display("FAIL b2b_extra_bytes: got %0d want 0", rx_q.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      len = (gap_q.size() > 0) ? gap_q.pop_front() : -1;
      checks++; if (len != 1) $display("FAIL b2b_gap%0d: got %0d want 1", i, len); else passed++;
    end
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, st);
    checks++; if (st !== 32'h4) $display("FAIL b2b_ovf_clear: got %h want 4", st); else passed++;
  endtask

  task automatic test_div_midbyte();
    logic [8:0] got;
    int         len;
    bus_write(2'd2, 32'd1);
    clear_monitor();
    bus_write(2'd0, 32'h1F0);
    bus_write(2'd0, 32'h00F);
    repeat (3) @(negedge clk);
    bus_write(2'd2, 32'd5);
    wait_not_busy(300, "divmid_done");
    len = (len_q.size() > 0) ? len_q.pop_front() : -1;
    checks++; if (len != 36) $display("FAIL divmid_len_old: got %0d want 36", len); else passed++;
    len = (len_q.size() > 0) ? len_q.pop_front() : -1;
    checks++; if (len != 108) $display("FAIL divmid_len_new: got %0d want 108", len); else passed++;
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
    checks++; if (got !== 9'h1F0) $display("FAIL divmid_byte0: got %h want 1f0", got); else passed++;
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 'x;
    checks++; if (got !== 9'h00F) $display("FAIL divmid_byte1: got %h want 00f", got); else passed++;
  endtask

  task automatic test_reset_midbyte();
    logic [31:0] st;
    int          start_rise;
    int          snap;
    bit          reached = 0;
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'h155);
    bus_write(2'd0, 32'h0AA);
    start_rise = rise_cnt;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rise_cnt - start_rise >= 4) begin
        reached = 1;
        break;
      end
    end
    checks++; if (!reached) $display("FAIL rst_reach_bit3: rises %0d want 4", rise_cnt - start_rise); else passed++;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (lcd_cs_n !== 1'b1) $display("FAIL rst_cs_n: got %b want 1", lcd_cs_n); else passed++;
    checks++; if (lcd_scl !== 1'b1) $display("FAIL rst_scl: got %b want 1", lcd_scl); else passed++;
    checks++; if (lcd_si !== 1'b0) $display("FAIL rst_si: got %b want 0", lcd_si); else passed++;
    checks++; if (lcd_a0 !== 1'b0) $display("FAIL rst_a0: got %b want 0", lcd_a0); else passed++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_monitor();
    bus_read(2'd1, st);
    checks++; if (st !== 32'h4) $display("FAIL rst_status: got %h want 4", st); else passed++;
    snap = rise_cnt;
    repeat (30) @(negedge clk);
    checks++; if (rise_cnt != snap) $display("FAIL rst_no_scl: got %0d rises want 0", rise_cnt - snap); else passed++;
    checks++; if (lcd_cs_n !== 1'b1) $display("FAIL rst_cs_idle: got %b want 1", lcd_cs_n); else passed++;
  endtask

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    reset_n        = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_byte_div0();
    test_byte_div2();
    test_back_to_back();
    test_div_midbyte();
    test_reset_midbyte();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lcd_serial_tx.md
# lcd_serial_tx

Avalon-MM slave that serialises LCD command/data bytes onto a 4-wire SPI-style LCD bus (SI, SCL, A0, CS_n). Replaces CPU bit-banging of the single-bit SI output port: software writes a byte plus A0 flag, and the block clocks it out MSB-first. A small FIFO lets the CPU queue a burst of commands. Sits on the system Avalon bus next to the other LCD control ports and drives the LCD pins directly.

## Interface

- CLK_DIV, 4, reset value of DIV register; SCL half-period = DIV+1 clk cycles
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, ≥2
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  combinational read mux, unused bits 0
- lcd_si  out  1  serial data to LCD
- lcd_scl  out  1  serial clock, idle high
- lcd_a0  out  1  command(0)/data(1) select
- lcd_cs_n  out  1  LCD chip select, active low

## Operation

- Write = chipselect && !write_n, sampled on rising clk. No wait states.
- addr 0 TXDATA (W): push {writedata[8]=A0, writedata[7:0]=byte}. Reads 0.
- addr 1 STATUS (R): bit0 busy (FSM not IDLE or FIFO non-empty), bit1 full, bit2 empty, bit3 overflow (sticky). Write with writedata[3]=1 clears overflow.
- addr 2 DIV (R/W): bits[15:0]. Latched into FSM at byte start; mid-byte writes affect next byte only.
- addr 3: reads 0, writes ignored.
- Push accepted if FIFO not full, or full with a pop in the same cycle. Otherwise entry dropped, overflow set.
- Overflow set and clear in the same cycle: set wins.
- FSM, H = latched DIV+1 cycles per timed state:
  - IDLE: cs_n=1, scl=1. If FIFO non-empty, pop, load shifter, drive lcd_a0, latch DIV, go to SETUP.
  - SETUP (H): cs_n=0, scl=1, si=bit7. Then go to LO.
  - LO (H): scl=0, si=current bit. Then go to HI.
  - HI (H): scl=1; the LCD samples on this rising edge. After H, go to HOLD if bit count=7; otherwise shift, count++, go to LO.
  - HOLD (H): cs_n=0, scl=1, then IDLE.
- lcd_a0 holds its value from the last popped entry until the next pop.
- All outputs registered; glitch-free.

## Timing

- Reset values: lcd_cs_n=1, lcd_scl=1, lcd_si=0, lcd_a0=0, FIFO empty, overflow=0, DIV=CLK_DIV, FSM IDLE.
- Reset asserted mid-byte aborts immediately: outputs go to reset values and queued entries are lost.
- Write into empty FIFO at edge 0 while IDLE: lcd_cs_n=0, lcd_a0 and lcd_si valid after edge 1.
- Per byte: cs_n low for 18·H cycles. Between back-to-back bytes, cs_n high for exactly 1 cycle (IDLE).
- si changes only on SCL falling edges or at SETUP entry. Setup and hold to the SCL rising edge are each ≥H cycles.
- busy drops on the cycle after HOLD exits with the FIFO empty.
- The DIV=0xFFFF boundary gives H=65536, with no counter overflow.

## Test plan

- Reset, then read STATUS → 0x4; read DIV → CLK_DIV. Pins are cs_n=1, scl=1, si=0, a0=0.
- DIV=0, write 0x1A5 → a0=1, cs_n low 18 cycles. Bits sampled on 8 scl rising edges = 1,0,1,0,0,1,0,1.
- DIV=2, write 0x03C → a0=0, SCL half-period 3 cycles, cs_n low 54 cycles, byte 0x3C received.
- With FIFO_DEPTH=4, write 6 bytes back-to-back while idle → first byte popped cycle 1. 5 accepted, 6th dropped, overflow=1. 5 bytes out in order with 1-cycle cs_n gaps. Write STATUS 0x8 → overflow=0.
- Write DIV=5 mid-byte → current byte keeps old H; next byte uses H=6.
- Assert reset_n low during bit 3 → pins return to reset values at once. After release, STATUS=0x4 and no further SCL edges.
